// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types for the IF/MEM memory arbiter.
//   arbState_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   grant_t    : requester identity (FETCH, DATA)
//   pickGrant  : round-robin pick between the two requesters
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbState_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

  // A lone candidate always wins; with both pending the one that did not
  // win last time goes, so with lastGrant reset to FETCH data goes first.
  function automatic grant_t pickGrant(input logic ifCand, input logic dCand,
                                       input grant_t last);
    grant_t g;
    g = FETCH;
    if (ifCand && dCand) g = (last == FETCH) ? DATA : FETCH;
    else if (dCand)      g = DATA;
    return g;
  endfunction

endpackage

// File: rtl/Register.sv
// Register -- generic enabled register, asynchronous active-low reset to 0.
//   clk, rst : clock, async active-low reset
//   en       : load enable
//   d, q     : W-bit data in / registered out
module Register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog -- hung-memory watchdog for mem_arbiter.
// Only instantiated when MEM_ARB_WATCHDOG_EN is defined.
//   grant    : a new access starts next cycle; clears the counter
//   busy     : an access is outstanding this cycle
//   memReady : memory completes this cycle
//   fire     : force completion this cycle (TIMEOUT_CYCLES-th silent busy cycle)
//   timeout  : sticky flag, set after the first fire, cleared only by reset
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic busy,
  input  logic memReady,
  output logic fire,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of silent busy cycles already elapsed, so the
  // TIMEOUT_CYCLES-th one sees TIMEOUT_CYCLES-1 and fires.
  assign fire = busy && !memReady && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (grant)                 cnt <= '0;
      else if (busy && !memReady) cnt <= cnt + CW'(1);
      if (fire) timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported, variable-latency memory between
// the instruction-fetch stage and the data-memory stage.
//
// Optional feature: define MEM_ARB_WATCHDOG_EN to add a watchdog that forces
// completion (data 0) after TIMEOUT_CYCLES silent busy cycles and raises a
// sticky timeout flag. Without it, timeout is tied to 0.
//
// Ports:
//   clk, rst                  : clock, async active-low reset
//   ifReq/ifAddr              : fetch request (level, held until ifReady)
//   ifReady/ifData/ifFreeze   : fetch completion pulse, instruction, stall
//   dReq/dWe/dAddr/dWdata     : data request (level, held until dReady)
//   dReady/dRdata/dFreeze     : data completion pulse, read data, stall
//   memReq/memWe/memAddr/memWdata : registered memory request, stable while busy
//   memReady/memRdata         : memory completion and read data
//   timeout                   : sticky watchdog flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifReady,
  output logic [DATA_W-1:0] ifData,
  output logic              ifFreeze,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dReady,
  output logic [DATA_W-1:0] dRdata,
  output logic              dFreeze,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic              memReady,
  input  logic [DATA_W-1:0] memRdata,
  output logic              timeout
);

  arbState_t state, nextState;
  grant_t    lastGrant, nextLastGrant, grantSel;

  logic busy, completing, wdFire;
  logic ifCand, dCand, doGrant, memReqNext, weNext;
  logic [ADDR_W-1:0] addrNext;

  assign busy       = (state == BUSY_I) || (state == BUSY_D);
  // memReady outside a busy state is ignored entirely.
  assign completing = busy && (memReady || wdFire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastGrant <= FETCH;
    end else begin
      state     <= nextState;
      lastGrant <= nextLastGrant;
    end
  end

  // On completion the finishing requester is excluded from re-arbitration:
  // its req is still high this cycle but belongs to the access just served.
  // A watchdog-forced completion always returns to IDLE.
  always_comb begin
    nextState     = state;
    nextLastGrant = lastGrant;
    memReqNext    = memReq;
    ifReady       = 1'b0;
    dReady        = 1'b0;
    ifCand        = 1'b0;
    dCand         = 1'b0;
    case (state)
      IDLE: begin
        ifCand = ifReq;
        dCand  = dReq;
      end
      BUSY_I: begin
        if (completing) begin
          ifReady    = 1'b1;
          dCand      = dReq & ~wdFire;
          nextState  = IDLE;
          memReqNext = 1'b0;
        end
      end
      BUSY_D: begin
        if (completing) begin
          dReady     = 1'b1;
          ifCand     = ifReq & ~wdFire;
          nextState  = IDLE;
          memReqNext = 1'b0;
        end
      end
      default: begin
        nextState  = IDLE;
        memReqNext = 1'b0;
      end
    endcase
    grantSel = pickGrant(ifCand, dCand, lastGrant);
    doGrant  = ifCand | dCand;
    if (doGrant) begin
      nextState     = (grantSel == DATA) ? BUSY_D : BUSY_I;
      nextLastGrant = grantSel;
      memReqNext    = 1'b1;
    end
  end

  assign addrNext = (grantSel == DATA) ? dAddr : ifAddr;
  assign weNext   = (grantSel == DATA) & dWe;

  // Request registers load only on a grant, so they stay frozen for the
  // whole access regardless of what the requesters do meanwhile.
  Register #(.W(1)) uMemReq (
    .clk(clk), .rst(rst), .en(1'b1), .d(memReqNext), .q(memReq)
  );
  Register #(.W(1)) uMemWe (
    .clk(clk), .rst(rst), .en(doGrant), .d(weNext), .q(memWe)
  );
  Register #(.W(ADDR_W)) uMemAddr (
    .clk(clk), .rst(rst), .en(doGrant), .d(addrNext), .q(memAddr)
  );
  Register #(.W(DATA_W)) uMemWdata (
    .clk(clk), .rst(rst), .en(doGrant), .d(dWdata), .q(memWdata)
  );

  // Read data is a passthrough; a forced completion returns zero.
  assign ifData   = wdFire ? '0 : memRdata;
  assign dRdata   = wdFire ? '0 : memRdata;
  assign ifFreeze = ifReq & ~ifReady;
  assign dFreeze  = dReq & ~dReady;

`ifdef MEM_ARB_WATCHDOG_EN
  mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uWatchdog (
    .clk     (clk),
    .rst     (rst),
    .grant   (doGrant),
    .busy    (busy),
    .memReady(memReady),
    .fire    (wdFire),
    .timeout (timeout)
  );
`else
  logic [31:0] unusedTimeoutCycles;
  assign unusedTimeoutCycles = TIMEOUT_CYCLES;
  assign wdFire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed scoreboard bench for mem_arbiter.
// Stimulus pushes expected ready events and cycle-tagged bus probes into
// queues; a negedge monitor pops and compares them against the DUT.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [31:0] ifAddr = '0, dAddr = '0, dWdata = '0;
  logic        ifReady, ifFreeze, dReady, dFreeze;
  logic [31:0] ifData, dRdata;
  logic        memReq, memWe, memReady, timeout;
  logic [31:0] memAddr, memWdata, memRdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifReady(ifReady), .ifData(ifData),
    .ifFreeze(ifFreeze),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dReady(dReady), .dRdata(dRdata), .dFreeze(dFreeze),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memReady(memReady), .memRdata(memRdata), .timeout(timeout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ws wait states per access, respEn=0 hangs it,
  // forceRdy drives a stray memReady.
  int   ws = 0;
  int   wcnt = 0;
  logic respEn = 1'b1, forceRdy = 1'b0;
  assign memReady = (memReq && respEn && (wcnt == ws)) || forceRdy;
  assign memRdata = {memAddr[15:0], 16'hC0DE};
  always @(posedge clk) begin
    if (!memReq || memReady) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  typedef struct {
    bit          isD;
    int          cyc;
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } rdy_t;

  typedef struct {
    string       name;
    int          cyc;
    logic [38:0] vec;   // {memReq, memWe, memAddr, ifFreeze, dFreeze, ifReady, dReady, timeout}
    bit          chkWd;
    logic [31:0] wd;
  } prb_t;

  rdy_t expQ[$];
  prb_t prbQ[$];
  int   nCmp = 0, nErr = 0;
  bit   done = 0;

  task automatic expRdy(input bit isD, input int c, input logic [31:0] a,
                        input bit we, input logic [31:0] d);
    rdy_t e;
    e.isD = isD; e.cyc = c; e.addr = a; e.we = we; e.data = d;
    expQ.push_back(e);
  endtask

  task automatic probe(input string n, input int c, input logic req, input logic we,
                       input logic [31:0] a, input logic ifF, input logic dF,
                       input logic ifR, input logic dR, input logic to,
                       input bit chkWd, input logic [31:0] wd);
    prb_t p;
    p.name = n; p.cyc = c; p.vec = {req, we, a, ifF, dF, ifR, dR, to};
    p.chkWd = chkWd; p.wd = wd;
    prbQ.push_back(p);
  endtask

  always @(negedge clk) begin : mon
    rdy_t        e;
    prb_t        p;
    logic [31:0] gotD;
    logic [38:0] gv;
    if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      e = expQ.pop_front();
      nCmp++; nErr++;
      $display("FAIL ready-missing cyc=%0d: no ready seen, required %s at cyc %0d",
               cyc, e.isD ? "dReady" : "ifReady", e.cyc);
    end
    if (ifReady || dReady) begin
      nCmp++;
      gotD = dReady ? dRdata : ifData;
      if (expQ.size() == 0) begin
        nErr++;
        $display("FAIL ready-unexpected cyc=%0d: ifReady=%b dReady=%b, required no pulse",
                 cyc, ifReady, dReady);
      end else begin
        e = expQ.pop_front();
        if ((ifReady && dReady) || (e.isD != dReady) || (e.cyc != cyc) ||
            (e.addr != memAddr) || (e.we != memWe) || (!e.we && gotD != e.data)) begin
          nErr++;
          $display("FAIL ready-event: got cyc=%0d ifR=%b dR=%b addr=%h we=%b data=%h, required cyc=%0d %s addr=%h we=%b data=%h",
                   cyc, ifReady, dReady, memAddr, memWe, gotD,
                   e.cyc, e.isD ? "dReady" : "ifReady", e.addr, e.we, e.data);
        end
      end
    end
    while (prbQ.size() > 0 && prbQ[0].cyc <= cyc) begin
      p = prbQ.pop_front();
      nCmp++;
      gv = {memReq, memWe, memAddr, ifFreeze, dFreeze, ifReady, dReady, timeout};
      if (p.cyc != cyc || gv != p.vec || (p.chkWd && memWdata != p.wd)) begin
        nErr++;
        $display("FAIL probe %s cyc=%0d: got {req,we,addr,ifF,dF,ifR,dR,to}=%h wd=%h, required %h wd=%h (at cyc %0d)",
                 p.name, cyc, gv, memWdata, p.vec, p.wd, p.cyc);
      end
    end
    if (done) begin
      nCmp++;
      if (expQ.size() != 0 || prbQ.size() != 0) begin
        nErr++;
        $display("FAIL leftover: %0d ready events and %0d probes unchecked, required 0",
                 expQ.size(), prbQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
    end
    if (cyc > 3000) begin
      nCmp++; nErr++;
      $display("FAIL run-timeout: cyc=%0d, required end before 3000", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
    end
  end

  bit ifDrop, dDrop;

  // One cycle: just after the negedge, drop any request that was served.
  task automatic step();
    @(negedge clk); #2;
    ifDrop = 0; dDrop = 0;
    if (ifReq && ifReady) begin ifReq = 0; ifDrop = 1; end
    if (dReq && dReady)   begin dReq = 0;  dDrop = 1;  end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic doReset();
    @(negedge clk); #2;
    rst = 0; ifReq = 0; dReq = 0; dWe = 0; forceRdy = 0; respEn = 1;
    steps(2);
    rst = 1;
  endtask

  initial begin : stim
    int c, nI, nD;
    // Reset state
    steps(2);
    rst = 1;
    c = cyc;
    probe("reset", c + 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0);

    // 1: fetch alone, two wait states
    step();
    ws = 2; ifAddr = 32'h10; ifReq = 1; c = cyc;
    probe("t1-hold1", c + 1, 1, 0, 32'h10, 1, 0, 0, 0, 0, 0, 0);
    probe("t1-hold2", c + 2, 1, 0, 32'h10, 1, 0, 0, 0, 0, 0, 0);
    probe("t1-ready", c + 3, 1, 0, 32'h10, 0, 0, 1, 0, 0, 0, 0);
    probe("t1-idle",  c + 4, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    expRdy(0, c + 3, 32'h10, 0, 32'h0010C0DE);
    steps(5);

    // 2: both after reset, data write first, fetch back-to-back
    doReset();
    ws = 1; step(); c = cyc;
    dAddr = 32'h100; dWe = 1; dWdata = 32'hDEADBEEF; dReq = 1;
    ifAddr = 32'h4; ifReq = 1;
    probe("t2-dataIssue", c + 1, 1, 1, 32'h100, 1, 1, 0, 0, 0, 1, 32'hDEADBEEF);
    probe("t2-dataDone",  c + 2, 1, 1, 32'h100, 1, 0, 0, 1, 0, 0, 0);
    probe("t2-fetchNext", c + 3, 1, 0, 32'h4,   1, 0, 0, 0, 0, 0, 0);
    probe("t2-idle",      c + 5, 0, 0, 32'h4,   0, 0, 0, 0, 0, 0, 0);
    expRdy(1, c + 2, 32'h100, 1, 32'h0);
    expRdy(0, c + 4, 32'h4, 0, 32'h0004C0DE);
    steps(6);
    dWe = 0;

    // 3: both continuously requesting -> D,I,D,I,D,I
    doReset();
    ws = 0; step(); c = cyc;
    dAddr = 32'h200; dReq = 1; ifAddr = 32'h40; ifReq = 1;
    expRdy(1, c + 1, 32'h200, 0, 32'h0200C0DE);
    expRdy(0, c + 2, 32'h40,  0, 32'h0040C0DE);
    expRdy(1, c + 3, 32'h204, 0, 32'h0204C0DE);
    expRdy(0, c + 4, 32'h44,  0, 32'h0044C0DE);
    expRdy(1, c + 5, 32'h208, 0, 32'h0208C0DE);
    expRdy(0, c + 6, 32'h48,  0, 32'h0048C0DE);
    probe("t3-idle", c + 7, 0, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0);
    nI = 1; nD = 1;
    for (int k = 0; k < 7; k++) begin
      step();
      if (!dReq && !dDrop && nD < 3) begin dAddr = 32'h200 + 32'(4 * nD); dReq = 1; nD++; end
      if (!ifReq && !ifDrop && nI < 3) begin ifAddr = 32'h40 + 32'(4 * nI); ifReq = 1; nI++; end
    end

    // 4: memReady while IDLE is ignored
    step(); c = cyc; forceRdy = 1;
    probe("t4-stray1", c + 1, 0, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0);
    probe("t4-stray2", c + 2, 0, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0);
    steps(2);
    forceRdy = 0; ifAddr = 32'h80; ifReq = 1; c = cyc;
    expRdy(0, c + 1, 32'h80, 0, 32'h0080C0DE);
    steps(3);

    // 5: reset during BUSY_D, late memReady, data first again after
    respEn = 0; step(); c = cyc;
    dAddr = 32'h300; dWe = 0; dReq = 1;
    probe("t5-busy", c + 1, 1, 0, 32'h300, 0, 1, 0, 0, 0, 0, 0);
    steps(2);
    @(posedge clk); #1;
    rst = 0;
    probe("t5-asyncRst", cyc, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1, 32'h0);
    step(); dReq = 0; respEn = 1;
    step(); rst = 1; forceRdy = 1; c = cyc;
    probe("t5-lateRdy", c + 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step(); forceRdy = 0; c = cyc;
    dAddr = 32'h310; dReq = 1; ifAddr = 32'h50; ifReq = 1;
    expRdy(1, c + 1, 32'h310, 0, 32'h0310C0DE);
    expRdy(0, c + 2, 32'h50,  0, 32'h0050C0DE);
    steps(4);

`ifdef MEM_ARB_WATCHDOG_EN
    // 6: hung memory, watchdog fires on the 8th busy cycle
    respEn = 0; step(); c = cyc;
    ifAddr = 32'hA0; ifReq = 1;
    expRdy(0, c + 8, 32'hA0, 0, 32'h0);
    probe("t6-fire", c + 8, 1, 0, 32'hA0, 0, 0, 1, 0, 0, 0, 0);
    probe("t6-stop", c + 9, 0, 0, 32'hA0, 0, 0, 0, 0, 1, 0, 0);
    steps(9);
    respEn = 1; step(); c = cyc;
    ifAddr = 32'hB0; ifReq = 1;
    expRdy(0, c + 1, 32'hB0, 0, 32'h00B0C0DE);
    probe("t6-sticky", c + 2, 0, 0, 32'hB0, 0, 0, 0, 0, 1, 0, 0);
    steps(3);
    doReset(); c = cyc;
    probe("t6-cleared", c + 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    steps(2);
`endif

    step();
    done = 1;
  end

endmodule
